// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: VGA timing plus window-gated port-B reads, with sync/blank delayed to match RAM latency.
module vga_frame_scanner #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int X_OFF    = 192,
  parameter int Y_OFF    = 112,
  parameter int WIN_W    = 256,
  parameter int WIN_H    = 256,
  parameter int RD_LAT   = 1
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] ram_addr,
  output logic        ram_rden,
  input  logic [7:0]  ram_q,
  output logic [7:0]  pixel,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        busy,
  output logic        frame_done
);
  localparam logic [15:0] HA  = 16'(H_ACTIVE);
  localparam logic [15:0] HSS = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HSE = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] HL  = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] VA  = 16'(V_ACTIVE);
  localparam logic [15:0] VSS = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VSE = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] VL  = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] X0  = 16'(X_OFF);
  localparam logic [15:0] X1  = 16'(X_OFF + WIN_W - 1);
  localparam logic [15:0] Y0  = 16'(Y_OFF);
  localparam logic [15:0] Y1  = 16'(Y_OFF + WIN_H - 1);
  typedef enum logic [1:0] {IDLE, ARM, SCAN} state_t;
  state_t state, state_nx;
  logic [15:0] hcnt, vcnt, held, addr_win;
  logic [7:0] col, row;
  logic fb, in_win, last;
  logic [3:0] raw;
  logic [3:0] dly [RD_LAT];
  assign fb = hcnt == HL && vcnt == VL;
  assign in_win = hcnt >= X0 && hcnt <= X1 && vcnt >= Y0 && vcnt <= Y1;
  assign last = hcnt == X1 && vcnt == Y1;
  assign col = 8'(hcnt - X0);
  assign row = 8'(vcnt - Y0);
  assign addr_win = {row, col};
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= hcnt == HL ? '0 : hcnt + 16'd1;
      if (hcnt == HL) vcnt <= vcnt == VL ? '0 : vcnt + 16'd1;
    end
  end
  always_ff @(posedge vga_clk) begin
    state <= reset ? IDLE : state_nx;
    frame_done <= !reset && state == SCAN && fb;
  end
  // enable only matters at the frame boundary once armed, so frames are never cut short
  always_comb begin
    state_nx = state == IDLE ? (enable ? ARM : IDLE) : fb ? (enable ? SCAN : IDLE) : state;
  end
  always_comb begin
    busy = state == SCAN;
    ram_rden = busy && in_win;
    ram_addr = !busy ? 16'd0 : in_win ? addr_win : held;
  end
  // held address restarts at zero once the final window pixel has been read
  always_ff @(posedge vga_clk) begin
    held <= (reset || !busy || last) ? 16'd0 : in_win ? addr_win : held;
  end
  assign raw = {!(hcnt >= HSS && hcnt < HSE), !(vcnt >= VSS && vcnt < VSE), hcnt < HA && vcnt < VA, ram_rden};
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) dly[i] <= 4'b1100;
    end else begin
      dly[0] <= raw;
      for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
    end
  end
  assign hsync = dly[RD_LAT-1][3];
  assign vsync = dly[RD_LAT-1][2];
  assign blank_n = dly[RD_LAT-1][1];
  assign pixel = dly[RD_LAT-1][0] ? ram_q : 8'd0;
endmodule
